io_arbiter: RTL
===============

# io_arbiter

Shares the single-port I/O memory (nine 8-bit I/O registers at addresses 8'h00–8'h08) between two requesters: requester 0 is the CPU core and requester 1 is the serial debug/configuration loader. The block sits between both requesters and the `io` module's address/data/write_enable interface. It arbitrates round-robin, sequences each access through a fixed grant/acknowledge cycle and supports locked read-modify-write sequences with a timeout. It rejects out-of-range addresses without touching the I/O memory.

## Interface
Parameters:
- `LOCK_TIMEOUT`, 16: idle cycles a lock owner may hold the bus without requesting before the lock is revoked; range 1–255.

Ports:
- `clock`  in  1  system clock (50 MHz).
- `reset_s2_n`  in  1  reset, asynchronous, active-low.
- `req0` / `req1`  in  1  access request; held with its fields stable until `ack` is seen.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `lock0` / `lock1`  in  1  keep ownership after this access.
- `addr0` / `addr1`  in  8  I/O address.
- `wdata0` / `wdata1`  in  8  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `err0` / `err1`  out  1  pulse with `ack`: address > 8'h08.
- `rdata0` / `rdata1`  out  8  read data; valid with `ack`, held until that port's next `ack`.
- `io_address`  out  8  to `io.address`.
- `io_data_in`  out  8  to `io.data_in`.
- `io_write_enable`  out  1  to `io.write_enable`.
- `io_data_out`  in  8  from `io.data_out` (combinational read).
- `lock_timeout`  out  1  one-cycle pulse when a lock is revoked.

## Operation
- States: IDLE, GRANT, ACK, LOCK. Registered `owner` (0/1) and `last_grant` pointer.
- IDLE: sample `req0`/`req1`.
  - One request: grant it.
  - Both requests: grant the port ≠ `last_grant`.
  - Register `io_address`, `io_data_in` and `io_write_enable` (= `we && addr <= 8'h08`), then go to GRANT.
- GRANT: I/O signals are driven for exactly this cycle.
  - Capture `io_data_out` into `rdata[owner]`; capture 8'h00 if out of range.
  - Go to ACK.
- ACK: pulse `ack[owner]`, plus `err[owner]` if out of range.
  - Drive I/O outputs to 0.
  - Update `last_grant` = `owner`.
  - Go to LOCK if `lock[owner]` is high, else to IDLE.
- LOCK: only `req[owner]` is honoured; it is granted as in IDLE, without round-robin.
  - A request from the other port waits.
  - If `lock[owner]` falls while `req[owner]` is low, go to IDLE.
  - An 8-bit counter counts LOCK cycles with no owner request. When it reaches `LOCK_TIMEOUT`: pulse `lock_timeout`, go to IDLE, and set `last_grant` = `owner` so the other port wins the next tie.
- Writes to the read-only PIN registers are passed through; the `io` module overwrites them each cycle. The arbiter does not filter them.
- `req` is ignored in GRANT and ACK. A requester must drop `req`, or present a new access, in the cycle after `ack`.
- Out-of-range address: full GRANT/ACK sequence, `io_write_enable` stays 0, `rdata` = 8'h00, `err` = 1.

## Timing
- `req` sampled high at edge E0 (IDLE) → GRANT during E0–E1 → write lands at E1, read captured at E1 → `ack` high during E1–E2.
- Latency is 2 cycles from sampling edge to `ack`.
- Throughput: one access per 3 cycles from IDLE, or per 3 cycles under lock.
- Reset values: state IDLE, `last_grant` = 1 (port 0 wins the first tie), counter 0. Every output is 0, including `rdata0`, `rdata1`, `io_*` and `lock_timeout`.
- Reset mid-access (GRANT or ACK): the access is aborted, no `ack` is issued, and outputs return to 0 asynchronously.
  - A write already committed at an earlier edge remains; the `io` module is reset by the same signal anyway.
- A `lock` asserted on an out-of-range access is still honoured.

## Structure
- In package `def`: `IO_ADDR_MAX` = 8'h08 (shared with `io`), and the `io_arb_state_t` enum {IDLE, GRANT, ACK, LOCK}.
- No sub-module is needed. Round-robin selection is a local function, and the timeout counter is inline.
- Instantiated next to `io` in the microcomputer top level.

## Test plan
- Single write, then read: `req0` with `we0`=1, `addr0`=8'h01, `wdata0`=8'hA5 → `io_write_enable` high for exactly 1 cycle, `ack0` 2 cycles after sampling. A read of 8'h01 then gives `rdata0`=8'hA5.
- Simultaneous reads from both ports, repeated 4 times → grants alternate 0,1,0,1. Each port gets `ack` with correct data, and no cycle has both acks high.
- Out-of-range: `req1` write to 8'h09 with data 8'hFF → `io_write_enable` stays 0, `ack1`=`err1`=1, `rdata1`=8'h00, and memory is unchanged.
- Locked RMW: port 0 reads 8'h00 with `lock0`=1 while `req1` is held, then writes with `lock0`=0 → port 1 is granted only after port 0's second `ack`.
- Lock timeout with `LOCK_TIMEOUT`=4: port 0 locks then idles while `req1` is high → `lock_timeout` pulses 4 cycles into LOCK, and `ack1` follows 2 cycles after IDLE.
- Reset asserted during GRANT of a write → all outputs 0 immediately, no `ack`. After release, state is IDLE and port 0 wins the next tie.

Source files
------------

// File: rtl/io_arbiter_pkg.sv
// Shared definitions for the I/O memory arbiter.
//   IO_ADDR_MAX    : highest valid I/O register address (also used by io)
//   io_arb_state_t : arbiter sequencing states
package def;

  localparam logic [7:0] IO_ADDR_MAX = 8'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2,
    LOCK  = 2'd3
  } io_arb_state_t;

endpackage

// File: rtl/io_arbiter.sv
// io_arbiter: shares the single-port I/O register file between the CPU core
// (port 0) and the serial debug/configuration loader (port 1).
//
// Ports:
//   clock, reset_s2_n          : clock, asynchronous active-low reset
//   req/we/lock/addr/wdata 0|1 : per-requester access request, held until ack
//   ack/err/rdata 0|1          : completion pulse, out-of-range flag, read data
//   io_address/io_data_in/
//   io_write_enable            : registered drive into the io module
//   io_data_out                : combinational read data from the io module
//   lock_timeout               : one-cycle pulse when an idle lock is revoked
//
// Each access runs IDLE/LOCK -> GRANT -> ACK. The io_* outputs are registered
// on the grant edge so they are valid for the whole GRANT cycle only; a write
// lands on the edge that ends GRANT and read data is captured on that edge.
module io_arbiter
  import def::*;
#(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset_s2_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [7:0] io_address,
  output logic [7:0] io_data_in,
  output logic       io_write_enable,
  input  logic [7:0] io_data_out,
  output logic       lock_timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(LOCK_TIMEOUT);

  // On a tie the port that was not served last wins; otherwise whoever asks.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  io_arb_state_t state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          oor_q, oor_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    io_address_q, io_address_d;
  logic [7:0]    io_data_in_q, io_data_in_d;
  logic          io_we_q, io_we_d;
  logic [7:0]    rdata0_q, rdata0_d;
  logic [7:0]    rdata1_q, rdata1_d;

  logic          req_own, lock_own, gnt_port, sel_we, sel_in_range, lock_expire;
  logic [7:0]    sel_addr, sel_wdata, cnt_inc;

  assign req_own      = owner_q ? req1 : req0;
  assign lock_own     = owner_q ? lock1 : lock0;
  // Under lock only the owner can be granted, so round-robin is bypassed.
  assign gnt_port     = (state_q == LOCK) ? owner_q : rr_pick(req0, req1, last_grant_q);
  assign sel_addr     = gnt_port ? addr1 : addr0;
  assign sel_wdata    = gnt_port ? wdata1 : wdata0;
  assign sel_we       = gnt_port ? we1 : we0;
  assign sel_in_range = (sel_addr <= IO_ADDR_MAX);
  assign cnt_inc      = cnt_q + 8'd1;
  // Owner idle while still holding lock and this is the last allowed idle cycle.
  // A lock release in the same cycle takes priority and is not a timeout.
  assign lock_expire  = (state_q == LOCK) && !req_own && lock_own && (cnt_inc == TIMEOUT_CNT);

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      oor_q        <= 1'b0;
      cnt_q        <= 8'd0;
      io_address_q <= 8'd0;
      io_data_in_q <= 8'd0;
      io_we_q      <= 1'b0;
      rdata0_q     <= 8'd0;
      rdata1_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      oor_q        <= oor_d;
      cnt_q        <= cnt_d;
      io_address_q <= io_address_d;
      io_data_in_q <= io_data_in_d;
      io_we_q      <= io_we_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    oor_d        = oor_q;
    cnt_d        = cnt_q;
    // io_* are only non-zero for the GRANT cycle that follows a grant edge.
    io_address_d = 8'd0;
    io_data_in_d = 8'd0;
    io_we_d      = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = GRANT;
          owner_d      = gnt_port;
          oor_d        = !sel_in_range;
          io_address_d = sel_addr;
          io_data_in_d = sel_wdata;
          io_we_d      = sel_we && sel_in_range;
        end
      end
      GRANT: begin
        state_d = ACK;
        if (owner_q) rdata1_d = oor_q ? 8'd0 : io_data_out;
        else         rdata0_d = oor_q ? 8'd0 : io_data_out;
      end
      ACK: begin
        last_grant_d = owner_q;
        cnt_d        = 8'd0;
        state_d      = lock_own ? LOCK : IDLE;
      end
      LOCK: begin
        if (req_own) begin
          state_d      = GRANT;
          cnt_d        = 8'd0;
          oor_d        = !sel_in_range;
          io_address_d = sel_addr;
          io_data_in_d = sel_wdata;
          io_we_d      = sel_we && sel_in_range;
        end else if (!lock_own) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (lock_expire) begin
          // Revoked owner counts as last served so the other port wins next.
          state_d      = IDLE;
          cnt_d        = 8'd0;
          last_grant_d = owner_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ack0            = 1'b0;
    ack1            = 1'b0;
    err0            = 1'b0;
    err1            = 1'b0;
    if (state_q == ACK) begin
      ack0 = !owner_q;
      ack1 = owner_q;
      err0 = !owner_q && oor_q;
      err1 = owner_q && oor_q;
    end
    rdata0          = rdata0_q;
    rdata1          = rdata1_q;
    io_address      = io_address_q;
    io_data_in      = io_data_in_q;
    io_write_enable = io_we_q;
    lock_timeout    = lock_expire;
  end

endmodule
